// File: rtl/regbank_multiport.sv
// Multiport register file: two registered read ports, one byte-masked write port,
// optional hardwired zero register, write-to-read bypass and a valid/ready dump stream.
module regbank_multiport #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter bit ZERO_REG   = 1'b1,
   parameter bit BYPASS     = 1'b1
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    read_enable,
   input  logic [ADDR_WIDTH-1:0]   rd_addr_a,
   input  logic [ADDR_WIDTH-1:0]   rd_addr_b,
   output logic [DATA_WIDTH-1:0]   rd_data_a,
   output logic [DATA_WIDTH-1:0]   rd_data_b,
   input  logic                    write_enable,
   input  logic [ADDR_WIDTH-1:0]   wr_addr,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   input  logic [DATA_WIDTH/8-1:0] wr_mask,
   input  logic                    dump_start,
   output logic                    dump_busy,
   output logic                    dump_valid,
   input  logic                    dump_ready,
   output logic [ADDR_WIDTH-1:0]   dump_addr,
   output logic [DATA_WIDTH-1:0]   dump_data
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int BYTES = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic {IDLE, SCAN} dump_state_t;

   logic [DATA_WIDTH-1:0] regs [DEPTH];
   logic [DATA_WIDTH-1:0] wr_merged;
   logic [DATA_WIDTH-1:0] rd_next_a;
   logic [DATA_WIDTH-1:0] rd_next_b;
   logic                  wr_allowed;
   logic [ADDR_WIDTH-1:0] dump_addr_inc;
   dump_state_t           state;
   dump_state_t           next_state;
   logic                  dump_load_first;
   logic                  dump_advance;

   // Post-write value of the target register; shared by the write and the bypass.
   always_comb begin
      wr_merged = regs[wr_addr];
      for (int i = 0; i < BYTES; i++) begin
         if (wr_mask[i]) begin
            wr_merged[8*i +: 8] = wr_data[8*i +: 8];
         end
      end
   end

   assign wr_allowed = write_enable && !(ZERO_REG && (wr_addr == '0));

   always_comb begin
      rd_next_a = regs[rd_addr_a];
      if (ZERO_REG && (rd_addr_a == '0)) begin
         rd_next_a = '0;
      end else if (BYPASS && write_enable && (rd_addr_a == wr_addr)) begin
         rd_next_a = wr_merged;
      end
   end

   always_comb begin
      rd_next_b = regs[rd_addr_b];
      if (ZERO_REG && (rd_addr_b == '0)) begin
         rd_next_b = '0;
      end else if (BYPASS && write_enable && (rd_addr_b == wr_addr)) begin
         rd_next_b = wr_merged;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
         rd_data_a <= '0;
         rd_data_b <= '0;
      end else begin
         if (wr_allowed) begin
            regs[wr_addr] <= wr_merged;
         end
         if (read_enable) begin
            rd_data_a <= rd_next_a;
            rd_data_b <= rd_next_b;
         end
      end
   end

   assign dump_addr_inc = dump_addr + 1'b1;

   always_comb begin
      next_state      = state;
      dump_load_first = 1'b0;
      dump_advance    = 1'b0;
      case (state)
         IDLE: begin
            if (dump_start) begin
               next_state      = SCAN;
               dump_load_first = 1'b1;
            end
         end
         SCAN: begin
            if (dump_ready) begin
               if (dump_addr == LAST_ADDR) begin
                  next_state = IDLE;
               end else begin
                  dump_advance = 1'b1;
               end
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Entries are captured from the pre-write array contents and then frozen until accepted.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state     <= IDLE;
         dump_addr <= '0;
         dump_data <= '0;
      end else begin
         state <= next_state;
         if (dump_load_first) begin
            dump_addr <= '0;
            dump_data <= regs[0];
         end else if (dump_advance) begin
            dump_addr <= dump_addr_inc;
            dump_data <= regs[dump_addr_inc];
         end
      end
   end

   assign dump_busy  = (state == SCAN);
   assign dump_valid = (state == SCAN);

endmodule

// File: tb/tb_regbank_multiport.sv
// Directed self-checking bench for regbank_multiport with default parameters.
module tb_regbank_multiport;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        read_enable;
   logic [4:0]  rd_addr_a;
   logic [4:0]  rd_addr_b;
   logic [31:0] rd_data_a;
   logic [31:0] rd_data_b;
   logic        write_enable;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [3:0]  wr_mask;
   logic        dump_start;
   logic        dump_busy;
   logic        dump_valid;
   logic        dump_ready;
   logic [4:0]  dump_addr;
   logic [31:0] dump_data;

   int error_count = 0;
   int check_count = 0;

   regbank_multiport dut (
      .clock(clock), .reset_n(reset_n), .read_enable(read_enable),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
      .write_enable(write_enable), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
      .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
      .dump_ready(dump_ready), .dump_addr(dump_addr), .dump_data(dump_data)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      check_count++;
      if (observed !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Drives one datapath cycle (write and read ports) and advances past the edge.
   task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic [3:0] wm, input logic re,
                                input logic [4:0] ra, input logic [4:0] rb);
      write_enable = we;
      wr_addr      = wa;
      wr_data      = wd;
      wr_mask      = wm;
      read_enable  = re;
      rd_addr_a    = ra;
      rd_addr_b    = rb;
      tick();
      write_enable = 1'b0;
      read_enable  = 1'b0;
   endtask

   initial begin
      int exp_addr;
      logic [3:0] ready_pattern;

      reset_n = 1'b0; read_enable = 1'b0; rd_addr_a = '0; rd_addr_b = '0;
      write_enable = 1'b0; wr_addr = '0; wr_data = '0; wr_mask = '0;
      dump_start = 1'b0; dump_ready = 1'b0;
      tick();
      tick();
      checkOutput("reset_rd_a", rd_data_a, 32'h0);
      checkOutput("reset_busy", {31'b0, dump_busy}, 32'h0);
      reset_n = 1'b1;

      applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd3, 5'd31);
      checkOutput("read_after_reset_a", rd_data_a, 32'h0);
      checkOutput("read_after_reset_b", rd_data_b, 32'h0);
      checkOutput("idle_busy", {31'b0, dump_busy}, 32'h0);
      checkOutput("idle_valid", {31'b0, dump_valid}, 32'h0);

      // Byte-masked writes
      applyStimulus(1'b1, 5'd1, 32'hFFFF_FFFF, 4'b1111, 1'b0, 5'd0, 5'd0);
      applyStimulus(1'b1, 5'd1, 32'hAAAA_AAAA, 4'b0101, 1'b0, 5'd0, 5'd0);
      applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd1, 5'd1);
      checkOutput("mask_merge_a", rd_data_a, 32'hFFAA_FFAA);
      checkOutput("mask_merge_b", rd_data_b, 32'hFFAA_FFAA);
      applyStimulus(1'b1, 5'd1, 32'h0000_0000, 4'b0000, 1'b0, 5'd0, 5'd0);
      applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd1, 5'd0);
      checkOutput("mask_zero_noop", rd_data_a, 32'hFFAA_FFAA);

      // Partial-mask bypass on port B while port A reads the zero register
      applyStimulus(1'b1, 5'd1, 32'h1122_3344, 4'b1000, 1'b1, 5'd0, 5'd1);
      checkOutput("bypass_partial_b", rd_data_b, 32'h11AA_FFAA);
      checkOutput("zero_read_a", rd_data_a, 32'h0);

      // Zero register ignores writes, also under bypass
      applyStimulus(1'b1, 5'd0, 32'h1234_5678, 4'b1111, 1'b1, 5'd2, 5'd0);
      checkOutput("zero_bypass_b", rd_data_b, 32'h0);
      applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd0, 5'd1);
      checkOutput("zero_write_ignored", rd_data_a, 32'h0);
      checkOutput("partial_write_stored", rd_data_b, 32'h11AA_FFAA);

      applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 4'b1111, 1'b1, 5'd5, 5'd1);
      checkOutput("bypass_full_a", rd_data_a, 32'hDEAD_BEEF);
      applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd7, 5'd8);
      checkOutput("read_hold_a", rd_data_a, 32'hDEAD_BEEF);
      checkOutput("read_hold_b", rd_data_b, 32'h11AA_FFAA);

      for (int n = 1; n < 32; n++) begin
         applyStimulus(1'b1, 5'(n), 32'(n), 4'b1111, 1'b0, 5'd0, 5'd0);
      end

      // Full dump with ready held high; r11 is overwritten on the edge that loads entry 11
      dump_ready = 1'b1;
      dump_start = 1'b1;
      tick();
      dump_start = 1'b0;
      for (int i = 0; i < 32; i++) begin
         checkOutput($sformatf("dump_valid_%0d", i), {31'b0, dump_valid}, 32'h1);
         checkOutput($sformatf("dump_addr_%0d", i), {27'b0, dump_addr}, 32'(i));
         checkOutput($sformatf("dump_data_%0d", i), dump_data, 32'(i));
         if (i == 10) begin
            write_enable = 1'b1; wr_addr = 5'd11; wr_data = 32'h0000_CAFE; wr_mask = 4'b1111;
         end
         tick();
         write_enable = 1'b0;
      end
      checkOutput("dump_done_busy", {31'b0, dump_busy}, 32'h0);
      checkOutput("dump_done_valid", {31'b0, dump_valid}, 32'h0);
      applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd11, 5'd31);
      checkOutput("write_during_dump", rd_data_a, 32'h0000_CAFE);
      checkOutput("read_r31", rd_data_b, 32'd31);
      applyStimulus(1'b1, 5'd11, 32'd11, 4'b1111, 1'b0, 5'd0, 5'd0);

      // Backpressured dump; a second dump_start mid-scan must not restart it
      dump_ready = 1'b0;
      dump_start = 1'b1;
      tick();
      dump_start = 1'b0;
      ready_pattern = 4'b1001;
      exp_addr = 0;
      for (int cyc = 0; cyc < 40 && exp_addr != 7; cyc++) begin
         checkOutput($sformatf("bp_addr_c%0d", cyc), {27'b0, dump_addr}, 32'(exp_addr));
         checkOutput($sformatf("bp_data_c%0d", cyc), dump_data, 32'(exp_addr));
         dump_ready = ready_pattern[cyc % 4];
         dump_start = (cyc == 5);
         tick();
         dump_start = 1'b0;
         if (dump_ready) exp_addr++;
      end
      dump_ready = 1'b0;
      checkOutput("bp_reached_7", {27'b0, dump_addr}, 32'd7);
      checkOutput("bp_busy", {31'b0, dump_busy}, 32'h1);

      // Reset mid-dump
      read_enable = 1'b1; rd_addr_a = 5'd31; rd_addr_b = 5'd11;
      tick();
      read_enable = 1'b0;
      checkOutput("pre_reset_a", rd_data_a, 32'd31);
      reset_n = 1'b0;
      dump_ready = 1'b1;
      tick();
      reset_n = 1'b1;
      checkOutput("reset_dump_valid", {31'b0, dump_valid}, 32'h0);
      checkOutput("reset_dump_busy", {31'b0, dump_busy}, 32'h0);
      checkOutput("reset_rd_data_a", rd_data_a, 32'h0);
      checkOutput("reset_rd_data_b", rd_data_b, 32'h0);
      checkOutput("reset_dump_addr", {27'b0, dump_addr}, 32'h0);
      tick();
      checkOutput("reset_no_restart", {31'b0, dump_valid}, 32'h0);
      dump_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'(i), 5'(i + 16));
         checkOutput($sformatf("cleared_r%0d", i), rd_data_a, 32'h0);
         checkOutput($sformatf("cleared_r%0d", i + 16), rd_data_b, 32'h0);
      end

      $display("Result: errors=%0d of %0d checks", error_count, check_count);
      $finish;
   end

endmodule

// File: doc/regbank_multiport.md
# regbank_multiport

Parametrised register file succeeding the single-port 32×32 register bank. Provides two independent registered read ports and one byte-maskable write port for the datapath, with an optional hardwired-zero register 0 and a write-to-read bypass. A valid/ready debug dump port streams every register out in address order without stalling normal reads or writes. Sits between the decode stage (reads) and the writeback stage (write) of the pipeline.

## Interface
- DATA_WIDTH, 32, register width in bits; must be a multiple of 8
- ADDR_WIDTH, 5, address width; DEPTH = 2**ADDR_WIDTH registers
- ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes
- BYPASS, 1, 1 = same-cycle write to a read address is forwarded to the read output

- clock  in  1  single clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- read_enable  in  1  capture both read ports this edge
- rd_addr_a  in  ADDR_WIDTH  read port A address
- rd_addr_b  in  ADDR_WIDTH  read port B address
- rd_data_a  out  DATA_WIDTH  registered read data A
- rd_data_b  out  DATA_WIDTH  registered read data B
- write_enable  in  1  write strobe
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- wr_mask  in  DATA_WIDTH/8  byte enables; bit i covers wr_data[8i+7:8i]
- dump_start  in  1  request a full-register dump
- dump_busy  out  1  dump in progress
- dump_valid  out  1  dump_addr/dump_data hold a valid entry
- dump_ready  in  1  consumer accepts the current entry
- dump_addr  out  ADDR_WIDTH  address of the entry presented
- dump_data  out  DATA_WIDTH  value of the entry presented

## Operation
- Reset (reset_n low at an edge): all DEPTH registers := 0, rd_data_a/b := 0, dump FSM := IDLE, dump_valid := 0, dump_busy := 0, dump_addr := 0, dump_data := 0. Reset overrides every other input, including mid-dump (dump aborted, no further entries).
- Write: edge with write_enable=1 updates bytes of reg[wr_addr] whose wr_mask bit is 1; other bytes keep old value. wr_mask=0 is a no-op. ZERO_REG=1 and wr_addr=0: write discarded.
- Read: edge with read_enable=1 loads rd_data_a := reg[rd_addr_a], rd_data_b := reg[rd_addr_b]. read_enable=0: both outputs hold. Both ports may address the same register.
- Bypass: BYPASS=1, write_enable=1 and rd_addr_x == wr_addr on the same edge → rd_data_x gets the post-write merged value (old bytes where mask 0, wr_data bytes where mask 1). BYPASS=0 → pre-write value. Zero register always wins: ZERO_REG=1 and rd_addr_x=0 → 0.
- Dump FSM, states IDLE and SCAN:
  - IDLE, dump_start=1 → SCAN; dump_valid := 1, dump_addr := 0, dump_data := reg[0].
  - SCAN, dump_valid & dump_ready: if dump_addr == DEPTH-1 → IDLE, dump_valid := 0; else dump_addr := dump_addr+1, dump_data := reg[dump_addr+1].
  - SCAN, dump_ready=0: dump_addr/dump_data held stable.
  - dump_start ignored while in SCAN.
  - dump_busy = 1 exactly while in SCAN.
- Dump entries are sampled when loaded; a write on the loading edge is not reflected (pre-write value). Later writes do not alter an entry already presented. Reads and writes are never stalled by the dump.

## Timing
- Write latency: value visible to a read issued the edge after the write; same edge only via bypass.
- Read latency: 1 cycle (address at edge N → data valid after edge N).
- Dump: first entry valid 1 cycle after dump_start; with dump_ready held high, DEPTH entries on DEPTH consecutive cycles, dump_busy falls after the edge accepting address DEPTH-1.
- Address arithmetic is ADDR_WIDTH-bit unsigned; dump_addr never wraps past DEPTH-1.

## Test plan
- Reset then read_enable, rd_addr_a=3, rd_addr_b=31 → both 0x00000000 one cycle later; dump_busy=0, dump_valid=0.
- Write 0xFFFFFFFF to r1 mask 4'b1111, then 0xAAAAAAAA to r1 mask 4'b0101 → read r1 = 0xFFAAFFAA.
- Write 0x12345678 to r0 (ZERO_REG=1) → read r0 = 0; same edge write r5=0xDEADBEEF with rd_addr_a=5, BYPASS=1 → rd_data_a=0xDEADBEEF next cycle.
- Load rN=N for N=1..31, dump_start with dump_ready=1 → 32 consecutive entries addr 0..31, data 0,1..31; then dump_busy=0.
- Dump with dump_ready toggling 1,0,0,1 → entry held stable during low cycles, no address skipped or repeated; dump_start during SCAN ignored.
- reset_n low while dump_addr=7 → next cycle dump_valid=0, dump_busy=0, all registers and rd_data = 0.
